conv_ctrl_seq: RTL and testbench

//  Parametrised conv-layer control sequencer: one go/done job over num_pixels output pixels.

---
 rtl/conv_ctrl_pkg.sv | 34 +++
 rtl/conv_ctrl_seq_if.sv | 15 +
 rtl/conv_ctrl_ifmap_mux.sv | 33 +++
 rtl/conv_ctrl_seq.sv | 203 ++++++++++++++++++++
 tb/tb_conv_ctrl_seq.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and width helpers for the conv-layer control sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Counters indexing a single value still need one bit.
  function automatic int bit_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic int num_groups(input int num_mem, input int par);
    return num_mem / par;
  endfunction

  function automatic int num_one_pixel_cycle(input int num_mem, input int par, input int inter);
    return num_groups(num_mem, par) * inter;
  endfunction

endpackage

// File: rtl/conv_ctrl_seq_if.sv
// Job handshake between the layer top and the conv control sequencer.
interface conv_ctrl_seq_if #(
  parameter int NPIX_WIDTH = 16
);
  logic                  go;
  logic [NPIX_WIDTH-1:0] num_pixels;
  logic                  stall;
  logic                  busy;
  logic                  start;
  logic                  conv_done;
  logic [NPIX_WIDTH-1:0] pixel_count;

  modport master (output go, num_pixels, stall, input busy, start, conv_done, pixel_count);
  modport slave  (input go, num_pixels, stall, output busy, start, conv_done, pixel_count);
endinterface

// File: rtl/conv_ctrl_ifmap_mux.sv
// Selects the IFMAP_PAR consecutive memories of the active group; zero when disabled.
module conv_ctrl_ifmap_mux
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int INPUT_NUM_MEM = 20,
  parameter int IFMAP_PAR     = 1,
  parameter int GROUP_WIDTH   = 5
) (
  input  logic                              en,
  input  logic [GROUP_WIDTH-1:0]            group,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] q_b_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]   q_a_mux,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]   q_b_mux
);
  localparam int NUM_GROUPS = num_groups(INPUT_NUM_MEM, IFMAP_PAR);
  localparam int SLICE      = DATA_WIDTH * IFMAP_PAR;

  // Lanes of one group are adjacent memories, so each group is one contiguous slice.
  always_comb begin
    q_a_mux = '0;
    q_b_mux = '0;
    if (en) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (group == GROUP_WIDTH'(g)) begin
          q_a_mux = q_a_all[g*SLICE +: SLICE];
          q_b_mux = q_b_all[g*SLICE +: SLICE];
        end
      end
    end
  end
endmodule

// File: rtl/conv_ctrl_seq.sv
// Conv-layer control sequencer: one go/done job of num_pixels pixels with prime,
// run and drain phases, stall freeze and ifmap group selection.
//
//  state    | meaning
//  ST_IDLE  | waiting for go after reset
//  ST_PRIME | reads issued, filling the PIPE_DELAY read-to-MAC pipe
//  ST_RUN   | count_sload sweeps each pixel's groups
//  ST_DRAIN | no reads, MAC consumes the last PIPE_DELAY words
//  ST_DONE  | conv_done held until the next go
module conv_ctrl_seq
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH                = 16,
  parameter int INPUT_NUM_MEM             = 20,
  parameter int IFMAP_PAR                 = 1,
  parameter int NUM_ONE_PIXEL_CYCLE_INTER = 4,
  parameter int PIPE_DELAY                = 4,
  parameter int NPIX_WIDTH                = 16,
  localparam int NUM_GROUPS           = num_groups(INPUT_NUM_MEM, IFMAP_PAR),
  localparam int NUM_ONE_PIXEL_CYCLE  = num_one_pixel_cycle(INPUT_NUM_MEM, IFMAP_PAR, NUM_ONE_PIXEL_CYCLE_INTER),
  localparam int COUNT_SLOAD_BITWIDTH = bit_width(NUM_ONE_PIXEL_CYCLE)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  conv_ctrl_seq_if.slave                      job,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
  input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_a_mux_all,
  output logic [DATA_WIDTH*IFMAP_PAR-1:0]     in_feature_q_b_mux_all,
  output logic                                enable_addrger,
  output logic                                enable_weightaddrger,
  output logic                                enable_mult,
  output logic                                clear_mult,
  output logic                                in_feature_rden_a,
  output logic                                in_feature_rden_b,
  output logic                                weight_rden_a,
  output logic                                weight_rden_b,
  output logic                                in_feature_wren_a,
  output logic                                in_feature_wren_b,
  output logic                                weight_wren_a,
  output logic                                weight_wren_b,
  output logic                                accum_sload,
  output logic [COUNT_SLOAD_BITWIDTH-1:0]     count_sload
);
  localparam int CW = COUNT_SLOAD_BITWIDTH;
  localparam int GW = bit_width(NUM_GROUPS);
  localparam int IW = bit_width(NUM_ONE_PIXEL_CYCLE_INTER);
  localparam int PW = bit_width(PIPE_DELAY);
  localparam logic [CW-1:0] LAST_CNT   = CW'(NUM_ONE_PIXEL_CYCLE - 1);
  localparam logic [IW-1:0] LAST_INTER = IW'(NUM_ONE_PIXEL_CYCLE_INTER - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PIPE_DELAY - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic [IW-1:0]         inter_q, inter_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [NPIX_WIDTH-1:0] npix_q, npix_d;
  logic [NPIX_WIDTH-1:0] pix_q, pix_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  adv;
  logic [NPIX_WIDTH-1:0] pix_inc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grp_q   <= '0;
      inter_q <= '0;
      phase_q <= '0;
      npix_q  <= '0;
      pix_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      inter_q <= inter_d;
      phase_q <= phase_d;
      npix_q  <= npix_d;
      pix_q   <= pix_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    inter_d = inter_q;
    phase_d = phase_q;
    npix_d  = npix_q;
    pix_d   = pix_q;
    start_d = start_q;
    done_d  = done_q;
    adv     = !job.stall;
    pix_inc = pix_q + NPIX_WIDTH'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (adv && job.go) begin
          start_d = 1'b0;
          pix_d   = '0;
          phase_d = '0;
          if (job.num_pixels != '0) begin
            state_d = ST_PRIME;
            npix_d  = job.num_pixels;
            done_d  = 1'b0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        if (adv) begin
          if (phase_q == LAST_PHASE) begin
            state_d = ST_RUN;
            phase_d = '0;
            cnt_d   = '0;
            grp_d   = '0;
            inter_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      ST_RUN: begin
        if (adv) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            grp_d   = '0;
            inter_d = '0;
            pix_d   = pix_inc;
            start_d = 1'b1;
            if (pix_inc == npix_q) state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
            // Group advances every INTER cycles without a divider.
            if (inter_q == LAST_INTER) begin
              inter_d = '0;
              grp_d   = grp_q + GW'(1);
            end else begin
              inter_d = inter_q + IW'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (phase_q == LAST_PHASE) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic reading;
  assign reading = (state_q == ST_PRIME) || (state_q == ST_RUN);

  assign in_feature_rden_a    = reading;
  assign in_feature_rden_b    = reading;
  assign weight_rden_a        = reading;
  assign weight_rden_b        = reading;
  assign in_feature_wren_a    = 1'b0;
  assign in_feature_wren_b    = 1'b0;
  assign weight_wren_a        = 1'b0;
  assign weight_wren_b        = 1'b0;
  assign enable_addrger       = reading && adv;
  assign enable_weightaddrger = reading && adv;
  assign enable_mult          = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && adv;
  assign clear_mult           = (state_q == ST_PRIME) && (phase_q == '0) && adv;
  assign accum_sload          = (state_q == ST_RUN) && (cnt_q == '0) && adv;
  assign count_sload          = cnt_q;

  assign job.busy        = reading || (state_q == ST_DRAIN);
  assign job.start       = start_q;
  assign job.conv_done   = done_q;
  assign job.pixel_count = pix_q;

  conv_ctrl_ifmap_mux #(
    .DATA_WIDTH    (DATA_WIDTH),
    .INPUT_NUM_MEM (INPUT_NUM_MEM),
    .IFMAP_PAR     (IFMAP_PAR),
    .GROUP_WIDTH   (GW)
  ) u_ifmap_mux (
    .en      (state_q == ST_RUN),
    .group   (grp_q),
    .q_a_all (in_feature_q_a_all),
    .q_b_all (in_feature_q_b_all),
    .q_a_mux (in_feature_q_a_mux_all),
    .q_b_mux (in_feature_q_b_mux_all)
  );
endmodule

// File: tb/tb_conv_ctrl_seq.sv
// Bench for conv_ctrl_seq: each job is compared cycle by cycle against a model that
// derives every output from the count of non-stalled cycles since go.
module tb_conv_ctrl_seq;
  localparam int DW    = 16;
  localparam int NMEM  = 4;
  localparam int PAR   = 2;
  localparam int INTER = 3;
  localparam int PIPE  = 2;
  localparam int NPW   = 16;
  localparam int NG    = NMEM / PAR;
  localparam int NOPC  = NG * INTER;
  localparam int CSW   = 3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  conv_ctrl_seq_if #(.NPIX_WIDTH(NPW)) job_if ();

  logic [DW*NMEM-1:0] q_a_all, q_b_all;
  logic [DW*PAR-1:0]  mux_a, mux_b;
  logic en_addr, en_waddr, en_mult, clr_mult;
  logic if_rd_a, if_rd_b, w_rd_a, w_rd_b, if_wr_a, if_wr_b, w_wr_a, w_wr_b;
  logic accum_sload;
  logic [CSW-1:0] count_sload;

  conv_ctrl_seq #(
    .DATA_WIDTH(DW), .INPUT_NUM_MEM(NMEM), .IFMAP_PAR(PAR),
    .NUM_ONE_PIXEL_CYCLE_INTER(INTER), .PIPE_DELAY(PIPE), .NPIX_WIDTH(NPW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .job(job_if),
    .in_feature_q_a_all(q_a_all), .in_feature_q_b_all(q_b_all),
    .in_feature_q_a_mux_all(mux_a), .in_feature_q_b_mux_all(mux_b),
    .enable_addrger(en_addr), .enable_weightaddrger(en_waddr), .enable_mult(en_mult),
    .clear_mult(clr_mult),
    .in_feature_rden_a(if_rd_a), .in_feature_rden_b(if_rd_b),
    .weight_rden_a(w_rd_a), .weight_rden_b(w_rd_b),
    .in_feature_wren_a(if_wr_a), .in_feature_wren_b(if_wr_b),
    .weight_wren_a(w_wr_a), .weight_wren_b(w_wr_b),
    .accum_sload(accum_sload), .count_sload(count_sload)
  );

  wire [34:0] obs_w = {job_if.busy, job_if.start, job_if.conv_done,
                       if_rd_a, if_rd_b, w_rd_a, w_rd_b,
                       if_wr_a, if_wr_b, w_wr_a, w_wr_b,
                       en_addr, en_waddr, en_mult, clr_mult, accum_sload,
                       count_sload, job_if.pixel_count};
  wire [2*DW*PAR-1:0] mux_w = {mux_b, mux_a};

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] qa [NMEM];
  logic [DW-1:0] qb [NMEM];

  task automatic load_mem(input bit rnd);
    for (int m = 0; m < NMEM; m++) begin
      qa[m] = rnd ? DW'($urandom) : DW'(16'h11 * (m + 1));
      qb[m] = rnd ? DW'($urandom) : DW'(16'hA0 + m);
      q_a_all[m*DW +: DW] = qa[m];
      q_b_all[m*DW +: DW] = qb[m];
    end
  endtask

  // Runs one job from IDLE/DONE. mode 0: no stall, 1: random stall, 2: 3-cycle stall
  // at RUN cycle 4. go_at >= 0 injects a spurious go at that progress value.
  task automatic drive_job(input int npix, input int mode, input int go_at, input string tag,
                           output int lat, output int busy_cyc, output int sl0, output int sl1,
                           output logic [DW*PAR-1:0] mux_g0, output logic [DW*PAR-1:0] mux_g1);
    int r_len, t_end, k, run_rel, stall_left, budget, cnt, pix, g;
    bit s, fin, prime, run, drain, done_seen, go_used, stall_used, rd, ea;
    logic [34:0] exp_v;
    logic [DW*PAR-1:0] exp_a, exp_b;
    r_len = npix * NOPC;
    t_end = (npix == 0) ? 0 : 2 * PIPE + r_len;
    k = 0; run_rel = -1; stall_left = 0; lat = 0; busy_cyc = 0; sl0 = -1; sl1 = -1;
    mux_g0 = '0; mux_g1 = '0; done_seen = 0; go_used = 0; stall_used = 0;
    budget = 4 * t_end + 50;
    @(posedge clock); #1;
    job_if.go = 1'b1;
    job_if.num_pixels = NPW'(npix);
    @(posedge clock); #1;
    job_if.go = 1'b0;
    lat = 1;
    while (!done_seen && lat <= budget) begin
      job_if.go = 1'b0;
      if (go_at >= 0 && k == go_at && !go_used) begin
        job_if.go = 1'b1;
        job_if.num_pixels = NPW'(9);
        go_used = 1;
      end
      s = 0;
      if (k < t_end) begin
        if (mode == 1) s = ($urandom_range(0, 3) == 0);
        else if (mode == 2) begin
          if (k == PIPE + 4 && !stall_used) begin
            stall_left = 3;
            stall_used = 1;
          end
          s = (stall_left > 0);
          if (s) stall_left--;
        end
      end
      job_if.stall = s;
      #1;
      fin   = (k == t_end);
      prime = !fin && k < PIPE;
      run   = !fin && k >= PIPE && k < PIPE + r_len;
      drain = !fin && !prime && !run;
      cnt   = run ? (k - PIPE) % NOPC : 0;
      pix   = prime ? 0 : (run ? (k - PIPE) / NOPC : npix);
      g     = cnt / INTER;
      rd    = prime || run;
      ea    = rd && !s;
      exp_v = {!fin, pix >= 1, fin, rd, rd, rd, rd, 4'b0000, ea, ea,
               (run || drain) && !s, prime && k == 0 && !s, run && cnt == 0 && !s,
               CSW'(cnt), NPW'(pix)};
      exp_a = '0;
      exp_b = '0;
      if (run) begin
        for (int l = 0; l < PAR; l++) begin
          exp_a[l*DW +: DW] = qa[g*PAR + l];
          exp_b[l*DW +: DW] = qb[g*PAR + l];
        end
      end
      n_checks++;
      if (obs_w !== exp_v)
        $display("FAIL %s outputs k=%0d stall=%0d: got %h want %h", tag, k, s, obs_w, exp_v);
      else n_pass++;
      n_checks++;
      if (mux_w !== {exp_b, exp_a})
        $display("FAIL %s mux k=%0d: got %h want %h", tag, k, mux_w, {exp_b, exp_a});
      else n_pass++;
      if (run && run_rel < 0) run_rel = 0;
      if (accum_sload === 1'b1) begin
        if (sl0 < 0) sl0 = run_rel;
        else if (sl1 < 0) sl1 = run_rel;
      end
      if (run_rel == 0) mux_g0 = mux_a;
      if (run_rel == 3) mux_g1 = mux_a;
      if (job_if.busy === 1'b1) busy_cyc++;
      if (job_if.conv_done === 1'b1) done_seen = 1;
      else begin
        @(posedge clock); #1;
        lat++;
        if (!s && k < t_end) k++;
        if (run_rel >= 0) run_rel++;
      end
    end
    job_if.stall = 1'b0;
    job_if.go = 1'b0;
    n_checks++;
    if (!done_seen) $display("FAIL %s timeout: conv_done got 0 want 1 within %0d cycles", tag, budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs_w !== 35'd0 || mux_w !== '0)
      $display("FAIL reset_held: got %h/%h want 0/0", obs_w, mux_w);
    else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (obs_w !== 35'd0 || mux_w !== '0)
      $display("FAIL reset_released: got %h/%h want 0/0", obs_w, mux_w);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    load_mem(1);
    drive_job(2, 0, -1, "basic", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 17) $display("FAIL basic_done_latency: got %0d want 17", lat); else n_pass++;
    n_checks++;
    if (bc !== 16) $display("FAIL basic_busy_span: got %0d want 16", bc); else n_pass++;
    n_checks++;
    if (s0 !== 0 || s1 !== 6) $display("FAIL basic_sload_cycles: got %0d,%0d want 0,6", s0, s1);
    else n_pass++;
  endtask

  task automatic test_mux();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    load_mem(0);
    drive_job(1, 0, -1, "mux", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (m0 !== 32'h0022_0011) $display("FAIL mux_group0: got %h want 00220011", m0); else n_pass++;
    n_checks++;
    if (m1 !== 32'h0044_0033) $display("FAIL mux_group1: got %h want 00440033", m1); else n_pass++;
  endtask

  task automatic test_stall();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    load_mem(1);
    drive_job(2, 2, -1, "stall", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 20) $display("FAIL stall_done_latency: got %0d want 20", lat); else n_pass++;
    n_checks++;
    if (bc !== 19) $display("FAIL stall_busy_span: got %0d want 19", bc); else n_pass++;
  endtask

  task automatic test_zero_pixels();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    drive_job(0, 0, -1, "zero", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 1 || bc !== 0) $display("FAIL zero_latency_busy: got %0d,%0d want 1,0", lat, bc);
    else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if (if_rd_a !== 1'b0 || job_if.pixel_count !== '0 || job_if.conv_done !== 1'b1)
      $display("FAIL zero_hold: got rden=%b pix=%0d done=%b want 0,0,1",
               if_rd_a, job_if.pixel_count, job_if.conv_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    load_mem(1);
    @(posedge clock); #1;
    job_if.go = 1'b1;
    job_if.num_pixels = NPW'(3);
    @(posedge clock); #1;
    job_if.go = 1'b0;
    repeat (PIPE + 1) @(posedge clock);
    #1;
    n_checks++;
    if (job_if.busy !== 1'b1 || count_sload !== CSW'(1))
      $display("FAIL midrun_before_reset: got busy=%b cnt=%0d want 1,1", job_if.busy, count_sload);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs_w !== 35'd0 || mux_w !== '0)
      $display("FAIL midrun_reset_clear: got %h/%h want 0/0", obs_w, mux_w);
    else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive_job(1, 0, -1, "after_reset", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 1 + 2*PIPE + NOPC) $display("FAIL after_reset_latency: got %0d want %0d", lat, 1 + 2*PIPE + NOPC);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc, s0, s1;
    logic [DW*PAR-1:0] m0, m1;
    load_mem(1);
    drive_job(3, 0, PIPE + 2, "go_in_run", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 1 + 2*PIPE + 3*NOPC) $display("FAIL go_in_run_latency: got %0d want %0d", lat, 1 + 2*PIPE + 3*NOPC);
    else n_pass++;
    drive_job(1, 0, -1, "restart", lat, bc, s0, s1, m0, m1);
    n_checks++;
    if (lat !== 1 + 2*PIPE + NOPC) $display("FAIL restart_latency: got %0d want %0d", lat, 1 + 2*PIPE + NOPC);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, bc, s0, s1, np;
    logic [DW*PAR-1:0] m0, m1;
    for (int j = 0; j < 8; j++) begin
      load_mem(1);
      np = $urandom_range(1, 4);
      drive_job(np, 1, -1, "random", lat, bc, s0, s1, m0, m1);
      n_checks++;
      if (lat < 1 + 2*PIPE + np*NOPC)
        $display("FAIL random_latency: got %0d want >= %0d", lat, 1 + 2*PIPE + np*NOPC);
      else n_pass++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    job_if.go = 1'b0;
    job_if.num_pixels = '0;
    job_if.stall = 1'b0;
    load_mem(0);
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_basic();
    test_mux();
    test_stall();
    test_zero_pixels();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
